// File: rtl/uart_pkg.sv
// uart_pkg: shared word type, arbiter state encoding and width defaults for the UART TX path
package uart_pkg;
  localparam int DEF_BIT_PER_WORD = 8;
  localparam int DEF_W_OUT = 24;
  typedef logic [DEF_BIT_PER_WORD-1:0] word_t;
  typedef enum logic [1:0] {IDLE, OFFER, LOCK} arb_state_e;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder searching from ptr upward modulo NUM_REQ
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               any,
  output logic [IW-1:0]      idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) idx = IW'((int'(ptr) + k) % NUM_REQ);
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx between requesters with per-message grant lock and idle timeout
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BIT_PER_WORD = DEF_BIT_PER_WORD,
  parameter int W_OUT = DEF_W_OUT,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int NUM_WORDS = W_OUT / BIT_PER_WORD,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int LCW = $clog2(LOCK_TIMEOUT)
) (
  input  logic                                              clk,
  input  logic                                              rstn,
  input  logic [NUM_REQ-1:0]                                req_valid,
  input  logic [NUM_REQ-1:0]                                req_last,
  input  logic [NUM_REQ-1:0][NUM_WORDS-1:0][BIT_PER_WORD-1:0] req_data,
  output logic [NUM_REQ-1:0]                                req_ready,
  output logic                                              m_valid,
  output logic [NUM_WORDS-1:0][BIT_PER_WORD-1:0]            m_data,
  input  logic                                              m_ready,
  output logic [IW-1:0]                                     grant_id,
  output logic                                              busy,
  output logic                                              lock_err
);
  arb_state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, pick_idx, sel, nxt;
  logic [NUM_WORDS-1:0][BIT_PER_WORD-1:0] m_data_q, m_data_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic last_q, last_d, lock_err_q, lock_err_d, pick_any, take;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (.req(req_valid), .ptr(rr_ptr_q), .any(pick_any), .idx(pick_idx));
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    m_data_d = m_data_q;
    last_d = last_q;
    lock_cnt_d = lock_cnt_q;
    lock_err_d = 1'b0;
    req_ready = '0;
    nxt = grant_id_q == IW'(NUM_REQ - 1) ? '0 : grant_id_q + IW'(1);
    sel = state_q == LOCK ? grant_id_q : pick_idx;
    take = rstn && (state_q == IDLE ? pick_any : state_q == LOCK && req_valid[grant_id_q]);
    if (take) begin
      req_ready[sel] = 1'b1;
      m_data_d = req_data[sel];
      grant_id_d = sel;
      last_d = req_last[sel];
      lock_cnt_d = '0;
      state_d = OFFER;
    end
    if (state_q == OFFER && m_ready) begin
      rr_ptr_d = last_q ? nxt : rr_ptr_q;
      lock_cnt_d = '0;
      state_d = last_q ? IDLE : LOCK;
    end
    if (state_q == LOCK && !take) begin
      lock_err_d = lock_cnt_q == LCW'(LOCK_TIMEOUT - 1);
      lock_cnt_d = lock_err_d ? lock_cnt_q : lock_cnt_q + LCW'(1);
      rr_ptr_d = lock_err_d ? nxt : rr_ptr_q;
      state_d = lock_err_d ? IDLE : LOCK;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      m_data_q <= '0;
      last_q <= 1'b0;
      lock_cnt_q <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      m_data_q <= m_data_d;
      last_q <= last_d;
      lock_cnt_q <= lock_cnt_d;
      lock_err_q <= lock_err_d;
    end
  end
  assign m_valid = state_q == OFFER;
  assign m_data = m_data_q;
  assign grant_id = grant_id_q;
  assign busy = state_q != IDLE;
  assign lock_err = lock_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for the round-robin UART TX arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rstn;
  logic [3:0] req_valid, req_last, req_ready;
  logic [3:0][2:0][7:0] req_data;
  logic m_valid, m_ready, busy, lock_err;
  logic [2:0][7:0] m_data;
  logic [1:0] grant_id;
  int checks = 0;
  int errors = 0;
  uart_tx_arbiter #(.NUM_REQ(4), .BIT_PER_WORD(8), .W_OUT(24), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .grant_id(grant_id), .busy(busy), .lock_err(lock_err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rstn = 1'b0;
    req_valid = '0;
    req_last = '0;
    m_ready = 1'b1;
    tick();
    tick();
    rstn = 1'b1;
    #1;
  endtask
  task automatic test_reset;
    rstn = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    m_ready = 1'b1;
    tick();
    tick();
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== 24'h0) begin errors++; $display("FAIL reset_m_data got %h exp 000000", m_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    checks++; if (busy !== 1'b0 || lock_err !== 1'b0) begin errors++; $display("FAIL reset_busy_err got %b%b exp 00", busy, lock_err); end
    req_valid = '0;
    rstn = 1'b1;
    #1;
  endtask
  task automatic test_single;
    req_valid = 4'b0100;
    req_last = 4'b0100;
    req_data[2] = 24'hA53C0F;
    m_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 24'hA53C0F || grant_id !== 2'd2) begin errors++; $display("FAIL single_offer got v=%b d=%h g=%0d exp v=1 d=a53c0f g=2", m_valid, m_data, grant_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_offer_ready got %b exp 0000", req_ready); end
    tick();
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got v=%b b=%b exp 00", m_valid, busy); end
    req_valid = 4'b1011;
    req_last = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL single_ptr3 got %b exp 1000", req_ready); end
    tick();
    req_valid = '0;
    tick();
  endtask
  task automatic test_fairness;
    logic [1:0] exp_g;
    req_valid = 4'b1111;
    req_last = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[i] = 24'h100000 * (i + 1) + 24'h0000AA;
    m_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 2'(k % 4);
      checks++; if (req_ready !== 4'(1 << exp_g)) begin errors++; $display("FAIL fair_ready_%0d got %b exp %b", k, req_ready, 4'(1 << exp_g)); end
      tick();
      checks++; if (m_valid !== 1'b1 || grant_id !== exp_g || m_data !== req_data[exp_g]) begin errors++; $display("FAIL fair_grant_%0d got v=%b g=%0d d=%h exp v=1 g=%0d", k, m_valid, grant_id, m_data, exp_g); end
      tick();
    end
    req_valid = '0;
    tick();
  endtask
  task automatic test_lock;
    req_valid = 4'b1011;
    req_last = 4'b1001;
    req_data[0] = 24'h000001;
    req_data[1] = 24'h11AA01;
    req_data[3] = 24'h333333;
    m_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_b1_ready got %b exp 0010", req_ready); end
    tick();
    checks++; if (m_valid !== 1'b1 || grant_id !== 2'd1 || m_data !== 24'h11AA01) begin errors++; $display("FAIL lock_b1 got v=%b g=%0d d=%h exp v=1 g=1 d=11aa01", m_valid, grant_id, m_data); end
    req_data[1] = 24'h11BB02;
    tick();
    checks++; if (req_ready !== 4'b0010 || m_valid !== 1'b0) begin errors++; $display("FAIL lock_l1 got r=%b v=%b exp r=0010 v=0", req_ready, m_valid); end
    tick();
    checks++; if (m_valid !== 1'b1 || grant_id !== 2'd1 || m_data !== 24'h11BB02) begin errors++; $display("FAIL lock_b2 got v=%b g=%0d d=%h exp v=1 g=1 d=11bb02", m_valid, grant_id, m_data); end
    req_data[1] = 24'h11CC03;
    req_last[1] = 1'b1;
    tick();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_l2 got %b exp 0010", req_ready); end
    tick();
    checks++; if (m_valid !== 1'b1 || grant_id !== 2'd1 || m_data !== 24'h11CC03) begin errors++; $display("FAIL lock_b3 got v=%b g=%0d d=%h exp v=1 g=1 d=11cc03", m_valid, grant_id, m_data); end
    req_valid[1] = 1'b0;
    tick();
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lock_next got %b exp 1000", req_ready); end
    tick();
    checks++; if (grant_id !== 2'd3 || m_data !== 24'h333333) begin errors++; $display("FAIL lock_next_data got g=%0d d=%h exp g=3 d=333333", grant_id, m_data); end
    req_valid = '0;
    tick();
  endtask
  task automatic test_backpressure;
    req_valid = 4'b0100;
    req_last = 4'b1111;
    req_data[2] = 24'h5A5A77;
    m_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_accept got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b1111;
    req_data[2] = 24'hDEAD00;
    for (int k = 0; k < 50; k++) begin
      #1;
      checks++; if (m_valid !== 1'b1 || m_data !== 24'h5A5A77 || req_ready !== 4'b0000 || lock_err !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d got v=%b d=%h r=%b e=%b exp v=1 d=5a5a77 r=0000 e=0", k, m_valid, m_data, req_ready, lock_err); end
      tick();
    end
    req_valid = '0;
    m_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release got busy=%b exp 0", busy); end
  endtask
  task automatic test_timeout;
    req_valid = 4'b0011;
    req_last = 4'b0010;
    req_data[0] = 24'h00F00D;
    m_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL to_accept got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++; if (req_ready !== 4'b0000 || lock_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_lock_%0d got r=%b e=%b b=%b exp r=0000 e=0 b=1", k, req_ready, lock_err, busy); end
      tick();
    end
    checks++; if (lock_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_pulse got e=%b b=%b exp e=1 b=0", lock_err, busy); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL to_next got %b exp 0010", req_ready); end
    tick();
    checks++; if (lock_err !== 1'b0 || grant_id !== 2'd1) begin errors++; $display("FAIL to_after got e=%b g=%0d exp e=0 g=1", lock_err, grant_id); end
    req_valid = '0;
    tick();
  endtask
  task automatic test_reset_mid;
    req_valid = 4'b1000;
    req_last = 4'b1111;
    m_ready = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b1 || grant_id !== 2'd3) begin errors++; $display("FAIL rm_offer got v=%b g=%0d exp v=1 g=3", m_valid, grant_id); end
    req_valid = 4'b1111;
    rstn = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rm_state got v=%b b=%b g=%0d r=%b exp v=0 b=0 g=0 r=0000", m_valid, busy, grant_id, req_ready); end
    rstn = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_restart got %b exp 0001", req_ready); end
    req_valid = '0;
    tick();
  endtask
  initial begin
    test_reset();
    test_single();
    do_reset();
    test_fairness();
    test_lock();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ requesters using round-robin arbitration.
- Each requester offers one NUM_WORDS-wide beat per handshake; req_last marks the end of a multi-beat message.
- The grant stays locked to a requester until it sends its last beat, so messages never interleave on the line.
- The output side connects directly to uart_tx s_valid/s_data/s_ready.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- BIT_PER_WORD, 8, bits per UART word.
- W_OUT, 24, bits per beat (multiple of BIT_PER_WORD).
- NUM_WORDS, W_OUT/BIT_PER_WORD, localparam, words per beat.
- LOCK_TIMEOUT, 1024, idle cycles allowed inside a locked message before forced release (>=2).

Ports:
- clk, input, 1, clock.
- rstn, input, 1, synchronous active-low reset.
- req_valid, input, NUM_REQ, per-requester beat valid.
- req_last, input, NUM_REQ, per-requester last-beat flag, qualified by req_valid.
- req_data, input, [NUM_REQ][NUM_WORDS][BIT_PER_WORD], per-requester beat.
- req_ready, output, NUM_REQ, per-requester accept (combinational, at most one bit high).
- m_valid, output, 1, to uart_tx s_valid.
- m_data, output, [NUM_WORDS][BIT_PER_WORD], to uart_tx s_data (registered).
- m_ready, input, 1, from uart_tx s_ready.
- grant_id, output, $clog2(NUM_REQ), index of the current/last granted requester.
- busy, output, 1, high when state != IDLE.
- lock_err, output, 1, one-cycle pulse on timeout release.

Behaviour:
- Reset (sync, rstn=0 at posedge):
  - state=IDLE; rr_ptr=0; grant_id=0.
  - m_valid=0; m_data='0; lock_cnt=0; lock_err=0.
  - req_ready is all-zero while rstn=0.
- Reset mid-message drops the held beat; the UART side handles its own reset.
- Arbitration (rr_pick): winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- A transfer on a requester port = req_valid[i] && req_ready[i]. A transfer on the output = m_valid && m_ready.
- States: IDLE, OFFER, LOCK.
- IDLE:
  - m_valid=0.
  - If any req_valid: req_ready[winner]=1 in the same cycle. Next cycle: m_data<=req_data[winner], grant_id<=winner, last_q<=req_last[winner], state->OFFER.
  - Latency from accept to m_valid is 1 cycle.
- OFFER:
  - m_valid=1; m_data is held stable; all req_ready=0.
  - On m_valid && m_ready:
    - If last_q=1: rr_ptr<=(grant_id+1) mod NUM_REQ, state->IDLE.
    - Else: lock_cnt<=0, state->LOCK.
  - m_ready low holds OFFER indefinitely. No timeout applies in OFFER.
- LOCK:
  - m_valid=0. Only req_ready[grant_id] may assert, equal to req_valid[grant_id]. Other requesters are ignored.
  - On transfer: capture the beat as in IDLE, state->OFFER, lock_cnt<=0.
  - Otherwise lock_cnt increments. When lock_cnt reaches LOCK_TIMEOUT-1: lock_err pulses next cycle, rr_ptr<=grant_id+1, state->IDLE.
- A beat with req_last=1 accepted from IDLE is a single-beat message: OFFER then IDLE.
- Simultaneous requests resolve strictly by rr_ptr. A requester just served drops to lowest priority.
- Wrap: rr_ptr and grant_id+1 wrap at NUM_REQ-1 -> 0.
- Non-power-of-two NUM_REQ must work; pointer values >= NUM_REQ never occur.
- Fairness: with all requesters continuously valid and single-beat messages, grants cycle 0,1,2,3,0,...

Decomposition:
- Shared package uart_pkg:
  - BIT_PER_WORD and W_OUT defaults.
  - word_t typedef (logic [BIT_PER_WORD-1:0]).
  - arb_state_e enum {IDLE, OFFER, LOCK}.
- Sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: req vector, pointer.
  - Outputs: any, index.
  - Parameterised by NUM_REQ. Reused by later arbiters.

Test Plan:
- Single requester: req 2 valid with last=1, data 24'hA5_3C_0F, m_ready=1 -> req_ready[2] high 1 cycle; next cycle m_valid=1, m_data=24'hA5_3C_0F, grant_id=2; then IDLE and rr_ptr=3.
- All four valid, single-beat, m_ready=1 after each beat -> grant order 0,1,2,3,0. No requester is granted twice before the others are served.
- Locked message: req 1 sends 3 beats (last on the third) while req 0 and req 3 stay valid -> all 3 beats go out back-to-back from req 1 before any other grant; next grant goes to req 3.
- Backpressure: m_ready=0 for 50 cycles in OFFER -> m_valid and m_data held stable, all req_ready=0, no lock_err.
- Timeout with LOCK_TIMEOUT=8: req 0 sends a non-last beat, then drops valid -> lock_err pulses exactly once, 8 cycles after entering LOCK; the next grant goes to a waiting req 1.
- Reset: assert rstn=0 for 1 cycle during OFFER -> next cycle m_valid=0, busy=0, grant_id=0; the next arbitration starts from req 0.
